// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: PCBack/PCFront pair with one delay slot, hazard stalls,
// pending-target capture during stalls, and a registered nullify marker for IF/ID.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        le,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        nullify_req,
    output logic [31:0] pc_back,
    output logic [31:0] pc_front,
    output logic [31:0] pc_front_in,
    output logic        fetch_valid,
    output logic        squash_if,
    output logic        stalled
);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]  state;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic [31:0] eff_target;

    assign eff_target = {br_target[31:2], 2'b00};

    // A branch resolving this cycle beats one remembered from an earlier stall.
    always_comb begin
        pc_front_in = pc_front + STEP;
        if (br_taken) begin
            pc_front_in = eff_target;
        end else if (pend_valid) begin
            pc_front_in = pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_back     <= RESET_PC;
            pc_front    <= RESET_PC + STEP;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            squash_if   <= 1'b0;
            state       <= FILL;
        end else if (le) begin
            pc_back    <= pc_front;
            pc_front   <= pc_front_in;
            pend_valid <= 1'b0;
            squash_if  <= nullify_req;
            state      <= RUN;
        end else begin
            // PCs hold; a branch resolved while stalled must survive until release.
            if (br_taken) begin
                pend_target <= eff_target;
                pend_valid  <= 1'b1;
            end
            if (state != FILL) begin
                state <= STALL;
            end
        end
    end

    assign fetch_valid = (state != FILL);
    assign stalled     = (state == STALL);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a cycle-level reference model compared every
// cycle, plus hand-computed expectations at the interesting points.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        le;
    logic        br_taken;
    logic [31:0] br_target;
    logic        nullify_req;
    logic [31:0] pc_back;
    logic [31:0] pc_front;
    logic [31:0] pc_front_in;
    logic        fetch_valid;
    logic        squash_if;
    logic        stalled;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'd0), .STEP(32'd4)) dut (
        .clk(clk),
        .reset(reset),
        .le(le),
        .br_taken(br_taken),
        .br_target(br_target),
        .nullify_req(nullify_req),
        .pc_back(pc_back),
        .pc_front(pc_front),
        .pc_front_in(pc_front_in),
        .fetch_valid(fetch_valid),
        .squash_if(squash_if),
        .stalled(stalled)
    );

    always #5 clk = ~clk;

    // Reference model: what the fetch stage should look like after each edge.
    bit          m_valid = 0;
    logic [31:0] m_back, m_front, m_pend;
    bit          m_pend_valid, m_squash, m_started, m_stalled;

    function automatic logic [31:0] model_next();
        if (br_taken) return br_target & 32'hFFFF_FFFC;
        if (m_pend_valid) return m_pend;
        return m_front + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_back = 32'd0;
            m_front = 32'd4;
            m_pend_valid = 0;
            m_squash = 0;
            m_started = 0;
            m_stalled = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (le) begin
                logic [31:0] nxt;
                nxt = model_next();
                m_back = m_front;
                m_front = nxt;
                m_pend_valid = 0;
                m_squash = nullify_req;
                m_started = 1;
                m_stalled = 0;
            end else begin
                if (br_taken) begin
                    m_pend = br_target & 32'hFFFF_FFFC;
                    m_pend_valid = 1;
                end
                m_stalled = m_started;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle once reset has been seen, compare all outputs mid-period.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model pc_back", pc_back, m_back);
            checkOutput("model pc_front", pc_front, m_front);
            checkOutput("model pc_front_in", pc_front_in, model_next());
            checkOutput("model fetch_valid", {31'd0, fetch_valid}, {31'd0, m_started});
            checkOutput("model stalled", {31'd0, stalled}, {31'd0, m_stalled});
            checkOutput("model squash_if", {31'd0, squash_if}, {31'd0, m_squash});
        end
    end

    task automatic applyStimulus(input logic r, input logic l, input logic b,
                                 input logic [31:0] t, input logic n);
        reset = r;
        le = l;
        br_taken = b;
        br_target = t;
        nullify_req = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        le = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        nullify_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset pc_back", pc_back, 32'd0);
        checkOutput("reset pc_front", pc_front, 32'd4);
        checkOutput("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
        checkOutput("reset squash_if", {31'd0, squash_if}, 32'd0);

        // FILL holds while le=0, without becoming a stall
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fill stalled", {31'd0, stalled}, 32'd0);
        checkOutput("fill pc_back", pc_back, 32'd0);

        // Sequential fetch
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("seq fetch_valid", {31'd0, fetch_valid}, 32'd1);
        checkOutput("seq pc_back 4", pc_back, 32'd4);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("seq pc_front 12", pc_front, 32'd12);

        // Taken branch with one delay slot
        applyStimulus(0, 1, 1, 32'h40, 0);
        checkOutput("delay slot pc_back", pc_back, 32'd12);
        checkOutput("branch pc_front", pc_front, 32'h40);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("target pc_back", pc_back, 32'h40);
        checkOutput("target pc_front", pc_front, 32'h44);

        // Nullify marks the fetch only
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("nullify squash_if", {31'd0, squash_if}, 32'd1);
        checkOutput("nullify pc_back", pc_back, 32'h44);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("unnullify squash_if", {31'd0, squash_if}, 32'd0);
        checkOutput("unnullify pc_front", pc_front, 32'h4C);

        // Stall with a branch captured in the first stall cycle
        applyStimulus(0, 0, 1, 32'h23, 1);
        checkOutput("stall stalled", {31'd0, stalled}, 32'd1);
        checkOutput("stall squash held", {31'd0, squash_if}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stall pc_back held", pc_back, 32'h48);
        checkOutput("stall pending next", pc_front_in, 32'h20);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("release pc_front", pc_front, 32'h20);
        checkOutput("release stalled", {31'd0, stalled}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("pending cleared", pc_front, 32'h24);

        // Later stall branch overwrites the earlier one
        applyStimulus(0, 0, 1, 32'h100, 0);
        applyStimulus(0, 0, 1, 32'h203, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("overwrite pc_front", pc_front, 32'h200);

        // A live branch at release beats the pending target
        applyStimulus(0, 0, 1, 32'h300, 0);
        applyStimulus(0, 1, 1, 32'h404, 0);
        checkOutput("live beats pending", pc_front, 32'h404);

        // Reset mid-stall with a pending branch and competing inputs
        applyStimulus(0, 0, 1, 32'h80, 0);
        applyStimulus(1, 1, 1, 32'h90, 1);
        checkOutput("midreset pc_back", pc_back, 32'd0);
        checkOutput("midreset pc_front", pc_front, 32'd4);
        checkOutput("midreset fetch_valid", {31'd0, fetch_valid}, 32'd0);
        checkOutput("midreset squash_if", {31'd0, squash_if}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("post reset no pending", pc_front, 32'd8);

        // Wrap of the sequential increment
        applyStimulus(0, 1, 1, 32'hFFFF_FFF8, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap pc_front", pc_front, 32'hFFFF_FFFC);
        checkOutput("wrap pc_front_in", pc_front_in, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("wrap pc_back", pc_back, 32'hFFFF_FFFC);
        checkOutput("wrapped pc_front", pc_front, 32'd0);

        // Mixed tail exercised against the model only
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, (i % 3) != 1, (i % 4) == 2, 32'h1000 + 32'(i * 9), i[0]);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, PCBack value loaded on reset.
REQ-002 SHALL have parameter STEP, default 32'd4, sequential PC increment.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port le  input  1  load enable from hazard unit; 0 = stall fetch.
REQ-006 SHALL have port br_taken  input  1  EX-stage branch/jump resolved taken (J or COMB true).
REQ-007 SHALL have port br_target  input  32  EX-stage branch target byte address.
REQ-008 SHALL have port nullify_req  input  1  EX-stage request to nullify the next fetched instruction.
REQ-009 SHALL have port pc_back  output  32  PCBack, instruction memory fetch address.
REQ-010 SHALL have port pc_front  output  32  PCFront register value.
REQ-011 SHALL have port pc_front_in  output  32  next PCFront value, combinational.
REQ-012 SHALL have port fetch_valid  output  1  fetched instruction at pc_back is architecturally valid.
REQ-013 SHALL have port squash_if  output  1  IF/ID must convert the current fetch into a NOP.
REQ-014 SHALL have port stalled  output  1  sequencer is in STALL state.

Function
REQ-015 SHALL implement a FILL/RUN/STALL state machine; FILL is entered on reset.
REQ-016 SHALL have these transitions: FILL->RUN on le=1; RUN->STALL on le=0; STALL->RUN on le=1; FILL holds while le=0.
REQ-017 SHALL drive fetch_valid=0 in FILL and 1 in RUN and STALL; stalled=1 only in STALL.
REQ-018 SHALL compute the effective target as {br_target[31:2],2'b00}; bits [1:0] are ignored.
REQ-019 SHALL drive pc_front_in with the first true of: (1) the effective target when br_taken=1; (2) the pending target when pend_valid=1; (3) pc_front+STEP, modulo 2^32.
REQ-020 SHALL, on a clock edge with le=1: pc_back<=pc_front; pc_front<=pc_front_in; clear pend_valid.
REQ-021 SHALL implement delayed branching by REQ-020: exactly one delay-slot instruction (old pc_front) is fetched after a taken branch, before the target.
REQ-022 SHALL, on a clock edge with le=0, hold pc_back and pc_front.
REQ-023 SHALL, on a clock edge with le=0 and br_taken=1, load the effective target into the pending-target register and set pend_valid=1; a later br_taken during the same stall overwrites it.
REQ-024 SHALL, on a clock edge with le=1, load squash_if<=nullify_req; with le=0, squash_if holds its value.
REQ-025 SHALL NOT allow squash_if to alter PC sequencing; nullification only marks the fetched instruction.
REQ-026 SHALL wrap the increment silently: pc_front=32'hFFFFFFFC with STEP=4 yields pc_front_in=32'h00000000, with no flag.
REQ-027 SHALL give reset priority over le, br_taken and nullify_req in the same cycle.

Reset
REQ-028 SHALL, on a clock edge with reset=1, set pc_back=RESET_PC and pc_front=RESET_PC+STEP.
REQ-029 SHALL, on the same reset edge, clear pend_valid, set squash_if=0, and set state=FILL, giving fetch_valid=0 and stalled=0.
REQ-030 SHALL, on reset asserted mid-stall or mid-branch, discard any pending target; the first post-reset fetch address is RESET_PC.
REQ-031 SHALL give all outputs deterministic values from the first reset edge onward; no asynchronous path exists.

Verification
REQ-032 Reset then le=1 for 3 cycles -> pc_back sequence 0,4,8,12; pc_front 4,8,12,16; fetch_valid 0 then 1 after the first le=1 edge.
REQ-033 pc_back=8, pc_front=12, br_taken=1, br_target=32'h40, le=1 -> next edge pc_back=12 (delay slot), pc_front=0x40; following edge pc_back=0x40, pc_front=0x44.
REQ-034 Stall of 2 cycles with br_taken=1, br_target=32'h23 in the first stall cycle, then le=1 -> PCs held during stall, stalled=1; release edge gives pc_front=0x20, pend_valid cleared.
REQ-035 nullify_req=1 with le=1 at pc_front=16 -> next edge squash_if=1, pc_back=16; next edge with nullify_req=0 -> squash_if=0, PC sequencing unchanged.
REQ-036 pc_front=32'hFFFFFFFC, le=1 -> pc_front_in=0; after the edge pc_back=32'hFFFFFFFC, pc_front=0.
REQ-037 reset=1 together with br_taken=1 and le=1 mid-run -> pc_back=0, pc_front=4, fetch_valid=0, squash_if=0, no pending target afterwards.
